clb: RTL and testbench

CLB -- requirements
Module: clb

---
 rtl/clb_if.sv | 22 ++
 rtl/clb.sv | 115 +++++++++++
 tb/tb_clb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clb_if.sv
// Signal bundle for the configurable logic block: config shift chain plus logic inputs/outputs.
interface clb_if;
   logic shift_clk;
   logic shift_i;
   logic shift_o;
   logic a;
   logic b;
   logic c;
   logic d;
   logic x;
   logic y;

   modport master (
      output shift_clk, shift_i, a, b, c, d,
      input  shift_o, x, y
   );

   modport slave (
      input  shift_clk, shift_i, a, b, c, d,
      output shift_o, x, y
   );
endinterface

// File: rtl/clb.sv
// Configurable logic block: two 3-input LUTs (or one 4-input LUT), one flip-flop,
// configured through a 36-bit serial shift chain clocked by strobes sampled on k.
module clb #(
   parameter int LUT_CONFIG_LEN = 8,
   parameter int CLB_CONFIG_LEN = 20
) (
   input logic  k,
   input logic  rst_n,
   clb_if.slave bus
);

   localparam int CFG_W = CLB_CONFIG_LEN + 2 * LUT_CONFIG_LEN;

   logic [CFG_W-1:0]          cfg_q;
   logic [CFG_W-1:0]          cfg_d;
   logic                      sclk_q;
   logic                      q_q;
   logic                      q_d;

   logic [LUT_CONFIG_LEN-1:0] g_tbl_s;
   logic [LUT_CONFIG_LEN-1:0] f_tbl_s;
   logic [2:0]                f_sel_s;
   logic [2:0]                g_sel_s;
   logic [2:0]                f_idx_s;
   logic [2:0]                g_idx_s;
   logic [2:0]                abc_s;
   logic                      f_out_s;
   logic                      g_out_s;
   logic                      d_src_s;
   logic                      strobe_s;
   logic                      x_s;
   logic                      y_s;

   // LUT input routing and lookup; 4-input mode uses d to choose between the two tables.
   always_comb begin
      g_tbl_s = cfg_q[7:0];
      f_tbl_s = cfg_q[15:8];
      f_sel_s = cfg_q[34:32];
      g_sel_s = cfg_q[31:29];
      abc_s   = {bus.a, bus.b, bus.c};
      f_idx_s = 3'b000;
      g_idx_s = 3'b000;
      f_out_s = 1'b0;
      g_out_s = 1'b0;
      if (cfg_q[28]) begin
         f_idx_s = abc_s;
         g_idx_s = abc_s;
         f_out_s = bus.d ? f_tbl_s[abc_s] : g_tbl_s[abc_s];
         g_out_s = f_out_s;
      end else begin
         f_idx_s = {f_sel_s[2] ? q_q   : bus.a,
                    f_sel_s[1] ? bus.d : bus.b,
                    f_sel_s[0] ? bus.d : bus.c};
         g_idx_s = {g_sel_s[2] ? bus.b : bus.a,
                    g_sel_s[1] ? bus.c : q_q,
                    g_sel_s[0] ? bus.d : q_q};
         f_out_s = f_tbl_s[f_idx_s];
         g_out_s = g_tbl_s[g_idx_s];
      end
   end

   // Output multiplexers for x and y.
   always_comb begin
      x_s = 1'b0;
      y_s = 1'b0;
      case (cfg_q[19:18])
         2'b00:   x_s = f_out_s;
         2'b10:   x_s = g_out_s;
         default: x_s = q_q;
      endcase
      case (cfg_q[17:16])
         2'b01:   y_s = f_out_s;
         2'b10:   y_s = g_out_s;
         default: y_s = q_q;
      endcase
   end

   // Next-state for the config chain (one shift per strobe rising edge) and the flip-flop.
   always_comb begin
      strobe_s = bus.shift_clk & ~sclk_q;
      d_src_s  = cfg_q[20] ? g_out_s : f_out_s;
      if (strobe_s) begin
         cfg_d = {bus.shift_i, cfg_q[CFG_W-1:1]};
      end else begin
         cfg_d = cfg_q;
      end
      if (cfg_q[24] && bus.a) begin
         q_d = 1'b1;
      end else if (cfg_q[25] && bus.d) begin
         q_d = 1'b0;
      end else if (cfg_q[23]) begin
         q_d = d_src_s;
      end else begin
         q_d = q_q;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge k) begin
      if (!rst_n) begin
         cfg_q  <= {CFG_W{1'b0}};
         q_q    <= 1'b0;
         sclk_q <= 1'b0;
      end else begin
         cfg_q  <= cfg_d;
         q_q    <= q_d;
         sclk_q <= bus.shift_clk;
      end
   end

   assign bus.x       = x_s;
   assign bus.y       = y_s;
   assign bus.shift_o = cfg_q[0];

endmodule

// File: tb/tb_clb.sv
// Self-checking bench for clb: queue-based config model plus rule-level output model,
// checked every negative edge, with directed scenarios and literal expectations.
module tb_clb;
   logic k = 1'b0;
   logic rst_n = 1'b0;
   always #5 k = ~k;

   clb_if bus();
   clb dut (.k(k), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model state: mcfg[0] is the oldest shifted bit (cfg[0]), back is cfg[35]
   bit mcfg[$];
   bit mq;
   bit mprev;

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [35:0] mvec();
      logic [35:0] v;
      v = 36'h0;
      for (int i = 0; i < 36; i++) v[i] = mcfg[i];
      return v;
   endfunction

   // returns {x, y, flip-flop D value} from the field map rules
   function automatic logic [2:0] model_out(input logic [35:0] cv, input logic q,
                                            input logic ia, input logic ib,
                                            input logic ic, input logic id);
      logic [7:0] gt, ft;
      logic [2:0] fs, gs;
      int         n, fi, gi;
      logic       fo, go, xo, yo, dv;
      gt = cv[7:0];
      ft = cv[15:8];
      fs = cv[34:32];
      gs = cv[31:29];
      if (cv[28]) begin
         n  = ia * 4 + ib * 2 + ic;
         fo = id ? ft[n] : gt[n];
         go = fo;
      end else begin
         fi = (fs[2] ? q : ia) * 4 + (fs[1] ? id : ib) * 2 + (fs[0] ? id : ic);
         gi = (gs[2] ? ib : ia) * 4 + (gs[1] ? ic : q) * 2 + (gs[0] ? id : q);
         fo = ft[fi];
         go = gt[gi];
      end
      if (cv[19:18] == 2'd0) xo = fo;
      else if (cv[19:18] == 2'd2) xo = go;
      else xo = q;
      if (cv[17:16] == 2'd1) yo = fo;
      else if (cv[17:16] == 2'd2) yo = go;
      else yo = q;
      dv = cv[20] ? go : fo;
      return {xo, yo, dv};
   endfunction

   // advance one k edge: model next state from pre-edge inputs, then drive after edge
   task automatic tick();
      logic [35:0] cv;
      logic [2:0]  o;
      bit          nq, nprev, do_shift, sbit;
      cv = mvec();
      o  = model_out(cv, mq, bus.a, bus.b, bus.c, bus.d);
      nq = mq;
      do_shift = 1'b0;
      sbit = bus.shift_i;
      if (!rst_n) begin
         nq = 1'b0;
         nprev = 1'b0;
      end else begin
         if (cv[24] && bus.a) nq = 1'b1;
         else if (cv[25] && bus.d) nq = 1'b0;
         else if (cv[23]) nq = o[0];
         do_shift = bus.shift_clk && !mprev;
         nprev = bus.shift_clk;
      end
      @(posedge k);
      if (!rst_n) begin
         for (int i = 0; i < 36; i++) mcfg[i] = 1'b0;
      end else if (do_shift) begin
         void'(mcfg.pop_front());
         mcfg.push_back(sbit);
      end
      mq = nq;
      mprev = nprev;
      #1;
   endtask

   task automatic strobe(input logic bv);
      bus.shift_i = bv;
      bus.shift_clk = 1'b1;
      tick();
      bus.shift_clk = 1'b0;
      tick();
   endtask

   task automatic load(input logic [35:0] w, input int nbits);
      for (int i = 0; i < nbits; i++) strobe(w[i]);
   endtask

   task automatic set_abcd(input logic [3:0] v);
      {bus.a, bus.b, bus.c, bus.d} = v;
   endtask

   // continuous comparison against the model on every falling edge
   initial begin
      logic [2:0] o;
      forever begin
         @(negedge k);
         if (chk_en) begin
            o = model_out(mvec(), mq, bus.a, bus.b, bus.c, bus.d);
            check("model_x", {35'h0, bus.x}, {35'h0, o[2]});
            check("model_y", {35'h0, bus.y}, {35'h0, o[1]});
            check("model_shift_o", {35'h0, bus.shift_o}, {35'h0, mcfg[0]});
            check("model_q", {35'h0, dut.q_q}, {35'h0, mq});
         end
      end
   end

   initial begin
      logic [35:0] w1, w2, w3, wr;
      logic [3:0]  v;
      w1 = 36'h0_E002_8096;
      w2 = 36'h0_1009_FEE8;
      w3 = 36'h4_0180_9600;
      wr = 36'hA_5C3F_0196;
      for (int i = 0; i < 36; i++) mcfg.push_back(1'b0);
      mq = 1'b0;
      mprev = 1'b0;
      bus.shift_clk = 1'b0;
      bus.shift_i = 1'b0;
      set_abcd(4'h0);

      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk_en = 1'b1;
      check("rst_x", {35'h0, bus.x}, 36'h0);
      check("rst_y", {35'h0, bus.y}, 36'h0);
      check("rst_shift_o", {35'h0, bus.shift_o}, 36'h0);
      check("rst_cfg", dut.cfg_q, 36'h0);
      rst_n = 1'b1;
      tick();

      // AND3 on x, XOR3 of b,c,d on y
      load(w1, 36);
      check("w1_cfg", dut.cfg_q, w1);
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         set_abcd(v);
         #1;
         check("w1_x", {35'h0, bus.x}, {35'h0, v[3] & v[2] & v[1]});
         check("w1_y", {35'h0, bus.y}, {35'h0, v[2] ^ v[1] ^ v[0]});
         tick();
      end

      // 4-input majority-of-at-least-two
      set_abcd(4'h0);
      load(w2, 36);
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         set_abcd(v);
         #1;
         check("w2_x", {35'h0, bus.x}, {35'h0, $countones(v) >= 2});
         check("w2_y", {35'h0, bus.y}, {35'h0, $countones(v) >= 2});
         tick();
      end

      // sequential: set from a, then toggle via Q ^ b ^ c
      set_abcd(4'h0);
      load(w3, 36);
      set_abcd(4'b1000);
      tick();
      check("seq_set", {35'h0, bus.y}, 36'h1);
      set_abcd(4'b0000);
      tick();
      check("seq_hold", {35'h0, bus.y}, 36'h1);
      set_abcd(4'b0100);
      tick();
      check("seq_tog1", {35'h0, bus.y}, 36'h0);
      tick();
      check("seq_tog2", {35'h0, bus.y}, 36'h1);
      tick();
      check("seq_tog3", {35'h0, bus.y}, 36'h0);

      // replay: shift_o presents the loaded word LSB-first
      set_abcd(4'h0);
      load(wr, 36);
      check("wr_cfg", dut.cfg_q, wr);
      for (int i = 0; i < 36; i++) begin
         check("replay_bit", {35'h0, bus.shift_o}, {35'h0, wr[i]});
         strobe(1'b0);
      end
      check("replay_zero", dut.cfg_q, 36'h0);

      // a strobe held high for many edges shifts once
      bus.shift_i = 1'b1;
      bus.shift_clk = 1'b1;
      repeat (10) tick();
      bus.shift_clk = 1'b0;
      tick();
      check("hold_high_one_shift", dut.cfg_q, 36'h8_0000_0000);

      // reset mid-shift, strobe high during reset is ignored
      load(w1, 18);
      bus.shift_clk = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      check("midrst_cfg", dut.cfg_q, 36'h0);
      check("midrst_x", {35'h0, bus.x}, 36'h0);
      check("midrst_y", {35'h0, bus.y}, 36'h0);
      check("midrst_q", {35'h0, dut.q_q}, 36'h0);
      bus.shift_clk = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("postrst_cfg", dut.cfg_q, 36'h0);
      load(w1, 36);
      check("reload_cfg", dut.cfg_q, w1);
      for (int i = 0; i < 16; i++) begin
         v = i[3:0];
         set_abcd(v);
         #1;
         check("reload_x", {35'h0, bus.x}, {35'h0, v[3] & v[2] & v[1]});
         check("reload_y", {35'h0, bus.y}, {35'h0, v[2] ^ v[1] ^ v[0]});
         tick();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
